rv32_fetch_ctrl: RTL and testbench

Sequencing controller for the RV32 program counter and the instruction-memory port. Issues one fetch per PC value over a req/ack handshake and holds the fetched word until decode accepts it. Drives the PC mux selects and the PC update enable for sequential advance, relative (branch) redirect and absolute (jump) redirect. Drains and discards in-flight fetches on redirect, and flags a sticky fault on memory timeout.

---
 rtl/rv32_ctrl_pkg.sv | 27 ++
 rtl/rv32_fetch_timeout.sv | 29 ++
 rtl/rv32_fetch_ctrl.sv | 117 +++++++++++
 tb/tb_rv32_fetch_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/rv32_ctrl_pkg.sv
// rtl/rv32_ctrl_pkg.sv - shared fetch-controller types and PC select encodings
package rv32_ctrl_pkg;

  localparam int INSTR_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_HOLD  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FAULT = 3'd4
  } fetch_state_e;

  // Bit 1 drives pc_next_sel, bit 0 drives pc_alu_sel
  typedef enum logic [1:0] {
    SEL_SEQ = 2'b00,
    SEL_REL = 2'b01,
    SEL_ABS = 2'b10
  } pc_sel_e;

  function automatic pc_sel_e redirect_sel(input logic abs_taken, input logic rel_taken);
    if (abs_taken) return SEL_ABS;
    if (rel_taken) return SEL_REL;
    return SEL_SEQ;
  endfunction

endpackage

// File: rtl/rv32_fetch_timeout.sv
// rtl/rv32_fetch_timeout.sv - clearable wait counter with expiry flag for imem requests
module rv32_fetch_timeout #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam int W = $clog2(TIMEOUT_CYCLES);

  logic [W-1:0] cnt_q;

  assign expired_o = (cnt_q == W'(TIMEOUT_CYCLES - 1));

  // Saturates at the expiry value; the controller leaves for FAULT on that cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && !expired_o) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/rv32_fetch_ctrl.sv
// rtl/rv32_fetch_ctrl.sv - PC sequencing and instruction-fetch handshake controller
module rv32_fetch_ctrl
  import rv32_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        pc_value,
  output logic               pc_en,
  output logic               pc_next_sel,
  output logic               pc_alu_sel,
  input  logic               redirect_abs,
  input  logic               redirect_rel,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_ack,
  input  logic [31:0]        imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [31:0]        instr_pc,
  input  logic               instr_ready,
  output logic               fault,
  output logic [CNT_W-1:0]   fetch_count
);

  fetch_state_e        state_q;
  logic [INSTR_W-1:0]  instr_q;
  logic [31:0]         instr_pc_q;
  logic                instr_valid_q;
  logic                fault_q;
  logic [CNT_W-1:0]    count_q;

  logic    redirect, redir_act, advance, waiting, tmo_expired;
  pc_sel_e sel;

  assign redirect  = redirect_abs | redirect_rel;
  assign redir_act = redirect && (state_q inside {ST_FETCH, ST_HOLD, ST_DRAIN});
  assign advance   = (state_q == ST_HOLD) && instr_valid_q && instr_ready && !redirect;
  assign waiting   = (state_q == ST_FETCH) || (state_q == ST_DRAIN);

  assign pc_en       = redir_act | advance;
  assign sel         = redir_act ? redirect_sel(redirect_abs, redirect_rel) : SEL_SEQ;
  assign pc_next_sel = sel[1];
  assign pc_alu_sel  = sel[0];

  assign imem_req    = (state_q == ST_FETCH);
  assign imem_addr   = pc_value;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign fault       = fault_q;
  assign fetch_count = count_q;

  rv32_fetch_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (waiting && imem_ack),
    .inc_i    (waiting && !imem_ack),
    .expired_o(tmo_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      fault_q       <= 1'b0;
      count_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: state_q <= ST_FETCH;
        ST_FETCH: begin
          // An ack that coincides with a redirect belongs to the old path
          if (imem_ack) begin
            if (!redirect) begin
              instr_q       <= imem_rdata;
              instr_pc_q    <= pc_value;
              instr_valid_q <= 1'b1;
              state_q       <= ST_HOLD;
            end
          end else if (tmo_expired) begin
            fault_q <= 1'b1;
            state_q <= ST_FAULT;
          end else if (redirect) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_HOLD: begin
          if (redirect) begin
            instr_valid_q <= 1'b0;
            state_q       <= ST_FETCH;
          end else if (instr_ready) begin
            instr_valid_q <= 1'b0;
            count_q       <= count_q + CNT_W'(1);
            state_q       <= ST_FETCH;
          end
        end
        ST_DRAIN: begin
          if (imem_ack) begin
            state_q <= ST_FETCH;
          end else if (tmo_expired) begin
            fault_q <= 1'b1;
            state_q <= ST_FAULT;
          end
        end
        ST_FAULT: fault_q <= 1'b1;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_fetch_ctrl.sv
// tb/tb_rv32_fetch_ctrl.sv - scoreboard bench for rv32_fetch_ctrl
module tb_rv32_fetch_ctrl;

  localparam logic [31:0] ABS_TGT = 32'hff00ff00;
  localparam logic [31:0] IMM     = 32'h00000100;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  logic        clk, reset;
  logic [31:0] pc_value;
  logic        pc_en, pc_next_sel, pc_alu_sel;
  logic        redirect_abs, redirect_rel;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        instr_valid, instr_ready, fault;
  logic [31:0] instr, instr_pc, fetch_count;

  exp_t        exp_q[$];
  logic [31:0] addr_q[$];
  int          errors = 0;
  int          checks = 0;

  rv32_fetch_ctrl #(.TIMEOUT_CYCLES(16), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .pc_value(pc_value),
    .pc_en(pc_en), .pc_next_sel(pc_next_sel), .pc_alu_sel(pc_alu_sel),
    .redirect_abs(redirect_abs), .redirect_rel(redirect_rel),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .fault(fault), .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Acts as the PC register: samples the selects, updates after the edge
  task automatic adv();
    logic e, n, a;
    e = pc_en; n = pc_next_sel; a = pc_alu_sel;
    @(posedge clk); #1;
    if (e) pc_value = n ? ABS_TGT : (a ? pc_value + IMM : pc_value + 32'd4);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (imem_req && imem_ack) begin
        if (addr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ack: addr %h, no fetch expected", imem_addr);
        end else chk("fetch_addr", imem_addr, addr_q.pop_front());
      end
      if (instr_valid && instr_ready && !redirect_abs && !redirect_rel) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_accept: instr %h, none expected", instr);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("accept_instr", instr, e.instr);
          chk("accept_pc", instr_pc, e.pc);
          chk("accept_pc_en", {31'd0, pc_en}, 32'd1);
          chk("accept_sel", {30'd0, pc_next_sel, pc_alu_sel}, 32'd0);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; pc_value = '0; redirect_abs = 0; redirect_rel = 0;
    imem_ack = 0; imem_rdata = '0; instr_ready = 0;
    repeat (2) @(posedge clk); #1;
    chk("rst_req", {31'd0, imem_req}, 0);
    chk("rst_valid", {31'd0, instr_valid}, 0);
    chk("rst_fault", {31'd0, fault}, 0);
    chk("rst_count", fetch_count, 0);
    chk("rst_pc_en", {31'd0, pc_en}, 0);
    chk("rst_instr", instr, 0);
    reset = 1'b0;

    @(negedge clk); chk("idle_req", {31'd0, imem_req}, 0); adv();
    @(negedge clk); chk("t1_req", {31'd0, imem_req}, 1); chk("t1_addr", imem_addr, 0); adv();
    addr_q.push_back(32'h0); exp_q.push_back('{32'h00000013, 32'h0});
    imem_ack = 1; imem_rdata = 32'h00000013;
    @(negedge clk); adv();
    imem_ack = 0; instr_ready = 1;
    @(negedge clk); chk("t1_valid", {31'd0, instr_valid}, 1); chk("t1_cnt0", fetch_count, 0); adv();
    instr_ready = 0;
    @(negedge clk);
    chk("t1_cnt1", fetch_count, 1); chk("t1_valid_drop", {31'd0, instr_valid}, 0);
    chk("t1_next_addr", imem_addr, 4); chk("t1_req2", {31'd0, imem_req}, 1);
    adv();

    addr_q.push_back(32'h4); exp_q.push_back('{32'h00400093, 32'h4});
    imem_ack = 1; imem_rdata = 32'h00400093;
    @(negedge clk); adv();
    imem_ack = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_stall_valid", {31'd0, instr_valid}, 1);
      chk("t2_stall_pc_en", {31'd0, pc_en}, 0);
      chk("t2_stall_req", {31'd0, imem_req}, 0);
      chk("t2_stall_cnt", fetch_count, 1);
      adv();
    end
    instr_ready = 1;
    @(negedge clk); adv();
    instr_ready = 0;

    addr_q.push_back(32'h8);
    imem_ack = 1; imem_rdata = 32'h00000063;
    @(negedge clk); chk("t3_cnt2", fetch_count, 2); adv();
    imem_ack = 0; redirect_rel = 1; instr_ready = 1;
    @(negedge clk);
    chk("t3_pc_en", {31'd0, pc_en}, 1); chk("t3_alu_sel", {31'd0, pc_alu_sel}, 1);
    chk("t3_next_sel", {31'd0, pc_next_sel}, 0);
    adv();
    redirect_rel = 1; redirect_abs = 1; instr_ready = 0;
    @(negedge clk);
    chk("t3_valid_drop", {31'd0, instr_valid}, 0); chk("t3_cnt_kept", fetch_count, 2);
    chk("t3_rel_addr", imem_addr, 32'h108); chk("t4_req", {31'd0, imem_req}, 1);
    chk("t4_pc_en", {31'd0, pc_en}, 1); chk("t4_next_sel", {31'd0, pc_next_sel}, 1);
    chk("t4_alu_sel", {31'd0, pc_alu_sel}, 0);
    adv();
    redirect_rel = 0; redirect_abs = 0;
    @(negedge clk); chk("t4_drain_req", {31'd0, imem_req}, 0); adv();
    imem_ack = 1; imem_rdata = 32'hdeadbeef;
    @(negedge clk); chk("t4_drain_req2", {31'd0, imem_req}, 0); adv();
    imem_ack = 0;
    @(negedge clk);
    chk("t4_no_present", {31'd0, instr_valid}, 0);
    chk("t4_refetch_req", {31'd0, imem_req}, 1); chk("t4_refetch_addr", imem_addr, ABS_TGT);
    adv();

    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      chk("t5_wait_fault", {31'd0, fault}, 0); chk("t5_wait_req", {31'd0, imem_req}, 1);
      adv();
    end
    redirect_abs = 1;
    @(negedge clk);
    chk("t5_fault", {31'd0, fault}, 1); chk("t5_req", {31'd0, imem_req}, 0);
    chk("t5_redir_pc_en", {31'd0, pc_en}, 0); chk("t5_redir_sel", {31'd0, pc_next_sel}, 0);
    adv();
    redirect_abs = 0;
    @(negedge clk); chk("t5_sticky", {31'd0, fault}, 1);
    #2; reset = 1; pc_value = '0; #1;
    chk("t5_rst_fault", {31'd0, fault}, 0); chk("t5_rst_cnt", fetch_count, 0);
    @(posedge clk); #1; reset = 0;

    @(negedge clk); chk("t6_idle_req", {31'd0, imem_req}, 0); adv();
    @(negedge clk); chk("t6_req", {31'd0, imem_req}, 1); chk("t6_addr", imem_addr, 0);
    #2; reset = 1; imem_ack = 1; imem_rdata = 32'hbad0bad0; #1;
    chk("t6_async_req", {31'd0, imem_req}, 0); chk("t6_async_valid", {31'd0, instr_valid}, 0);
    @(posedge clk); #1; reset = 0;
    @(negedge clk); chk("t6_late_ack_req", {31'd0, imem_req}, 0); adv();
    imem_ack = 0;
    @(negedge clk);
    chk("t6_late_valid", {31'd0, instr_valid}, 0);
    chk("t6_fresh_req", {31'd0, imem_req}, 1); chk("t6_fresh_addr", imem_addr, 0);
    adv();
    addr_q.push_back(32'h0); exp_q.push_back('{32'h00100073, 32'h0});
    imem_ack = 1; imem_rdata = 32'h00100073;
    @(negedge clk); adv();
    imem_ack = 0; instr_ready = 1;
    @(negedge clk); adv();
    instr_ready = 0;
    @(negedge clk); chk("t6_cnt", fetch_count, 1); chk("t6_next_addr", imem_addr, 4);

    chk("addr_q_empty", addr_q.size(), 0);
    chk("exp_q_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
